data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Parametrised single-clock data memory controller for the CPU data path.
- Adds byte/halfword/word access with byte-lane write masking, sign/zero-extended loads with a ready strobe, and misalignment detection.
- Has an explicit PROG/RUN mode state machine for UART image loading.
- Sits between the CPU memory stage and the internal RAM array; the UART programmer owns the array in PROG mode.

Parameters:
- ADDR_W, 14, word-address bits; array depth = 2**ADDR_W words of 32 bits.
- INIT_PROG, 1, mode entered on reset: 1 = PROG, 0 = RUN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_read  in  1  CPU load request.
- m_write  in  1  CPU store request.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ld_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- addr  in  32  CPU byte address.
- d_in  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- d_out  out  32  load result, aligned and extended.
- rdy  out  1  one-cycle pulse: d_out valid for the last accepted load.
- misalign  out  1  one-cycle pulse: last request dropped as misaligned.
- busy  out  1  1 while in PROG mode.
- upg_start_i  in  1  request entry to PROG mode.
- upg_wen_i  in  1  UART word write enable.
- upg_adr_i  in  ADDR_W  UART word address.
- upg_dat_i  in  32  UART write data.
- upg_done_i  in  1  UART load complete.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - d_out = 0, rdy = 0, misalign = 0.
  - Mode = PROG when INIT_PROG = 1, else RUN; busy follows mode.
  - Array contents are not reset.
- States:
  - PROG → RUN when upg_done_i = 1.
  - RUN → PROG when upg_start_i = 1.
  - Both transitions take effect on the next edge.
  - upg_done_i and upg_start_i high together in RUN: the FSM goes to PROG (start wins).
- PROG mode:
  - upg_wen_i = 1 writes upg_dat_i to mem[upg_adr_i], full word.
  - CPU m_read/m_write are ignored; rdy and misalign stay 0; d_out holds its value.
  - A write in the same cycle as upg_done_i is still performed.
- RUN mode:
  - UART inputs other than upg_start_i are ignored.
  - Word index = addr[ADDR_W+1:2]; upper address bits are ignored, so the address space aliases/wraps.
- Alignment: a request is misaligned when size = 01 and addr[0] = 1, or size = 10/11 and addr[1:0] ≠ 00.
  - The access is dropped: no write, no rdy.
  - misalign pulses high the cycle after the request.
- Store (m_write = 1, aligned):
  - Completes at the edge where it is sampled.
  - Byte: lane addr[1:0] written with d_in[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} written with d_in[15:0].
  - Word: all 4 lanes written.
  - Unselected lanes are unchanged (per-byte write mask, no read-modify-write).
- Load (m_read = 1, aligned):
  - Request sampled at edge T; rdy = 1 and d_out valid after edge T+1. Latency is 1 cycle and back-to-back loads give rdy every cycle.
  - Selected byte/half is shifted to bit 0, then extended per ld_unsigned as captured at T.
  - d_out holds until the next completed load.
- m_read and m_write both high: the store is performed and the load is dropped (no rdy).
- Read-after-write to the same word in consecutive cycles returns the new data.
- Mode change with a load in flight:
  - A load sampled at the last RUN edge still completes: rdy and d_out update on the next edge even though mode is PROG.
- Reset mid-operation clears a pending rdy/misalign; no partial store.

Optional Feature:
- Macro DMEM_STAT_EN.
- Defined:
  - Adds output ports ld_cnt[31:0] and st_cnt[31:0].
  - They count completed loads and stores in RUN, saturating at 0xFFFFFFFF.
  - Cleared by reset and on every RUN → PROG transition.
  - Misaligned or dropped requests are not counted.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with INIT_PROG = 1 → busy = 1. UART writes 0x11223344 @ 0 and 0x8000FF7F @ 1, then upg_done_i → busy = 0 next cycle.
- Word load from addr 0x0 → rdy one cycle later, d_out = 0x11223344. Byte load from 0x4, signed → d_out = 0x0000007F. Byte load from 0x5, signed → d_out = 0xFFFFFFFF. Half load from 0x6, unsigned → d_out = 0x00008000.
- Store byte 0xAB to 0x2, then word load from 0x0 in the next cycle → d_out = 0x11AB3344. Store half 0xBEEF to 0x0, then word load → 0x11ABBEEF.
- Word load from 0x2 and half store to 0x3 → misalign pulses each time, no rdy, memory unchanged (word 0 still 0x11ABBEEF).
- In RUN, assert upg_start_i together with m_read → that load completes (rdy = 1), busy = 1. Subsequent m_write 0xDEADBEEF to 0x0 is ignored. After upg_done_i, word 0 reads 0x11ABBEEF.
- Assert rst_n = 0 asynchronously mid-cycle while a load is pending → rdy = 0 and d_out = 0 immediately. With DMEM_STAT_EN defined, ld_cnt and st_cnt = 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// CPU data memory controller: sized loads/stores, misalign detect, UART PROG/RUN mode.
// Optional `DMEM_STAT_EN adds saturating load/store counters (ld_cnt, st_cnt).
module data_mem_ctrl #(
    parameter int ADDR_W    = 14,
    parameter bit INIT_PROG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_read,
    input  logic              m_write,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       d_in,
    output logic [31:0]       d_out,
    output logic              rdy,
    output logic              misalign,
    output logic              busy,
    input  logic              upg_start_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    input  logic              upg_done_i
`ifdef DMEM_STAT_EN
    ,
    output logic [31:0]       ld_cnt,
    output logic [31:0]       st_cnt
`endif
);

    typedef enum logic {PROG, RUN} mode_e;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    mode_e             mode_q, mode_d;
    logic [31:0]       d_out_q, d_out_d;
    logic              rdy_q, rdy_d;
    logic              mis_q, mis_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        sz_q, sz_d;
    logic              uns_q, uns_d;

    logic              run, mis, st_en, ld_acc;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rword;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic              unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];
    assign idx         = addr[ADDR_W+1:2];
    assign run         = (mode_q == RUN);

    always_comb begin
        mis = 1'b0;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr[0];
            default: mis = |addr[1:0];
        endcase
        st_en  = run && m_write && !mis;
        ld_acc = run && m_read && !m_write && !mis;

        be    = 4'b1111;
        wdata = d_in;
        case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{d_in[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{d_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Pending load reads the array during its second cycle and lands in d_out.
    always_comb begin
        rword = mem[idx_q];
        rbyte = rword[{off_q, 3'b000} +: 8];
        rhalf = off_q[1] ? rword[31:16] : rword[15:0];

        d_out_d = d_out_q;
        if (pend_q) begin
            case (sz_q)
                2'b00:   d_out_d = {{24{~uns_q & rbyte[7]}}, rbyte};
                2'b01:   d_out_d = {{16{~uns_q & rhalf[15]}}, rhalf};
                default: d_out_d = rword;
            endcase
        end
        rdy_d  = pend_q;
        mis_d  = run && (m_read || m_write) && mis;
        pend_d = ld_acc;
        idx_d  = ld_acc ? idx : idx_q;
        off_d  = ld_acc ? addr[1:0] : off_q;
        sz_d   = ld_acc ? size : sz_q;
        uns_d  = ld_acc ? ld_unsigned : uns_q;

        mode_d = mode_q;
        case (mode_q)
            PROG:    if (upg_done_i) mode_d = RUN;
            default: if (upg_start_i) mode_d = PROG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= INIT_PROG ? PROG : RUN;
            d_out_q <= '0;
            rdy_q   <= 1'b0;
            mis_q   <= 1'b0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            sz_q    <= '0;
            uns_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            d_out_q <= d_out_d;
            rdy_q   <= rdy_d;
            mis_q   <= mis_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            sz_q    <= sz_d;
            uns_q   <= uns_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!run && upg_wen_i) begin
            mem[upg_adr_i] <= upg_dat_i;
        end else if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign d_out    = d_out_q;
    assign rdy      = rdy_q;
    assign misalign = mis_q;
    assign busy     = !run;

`ifdef DMEM_STAT_EN
    logic [31:0] ld_cnt_q, ld_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (run && upg_start_i) begin
            ld_cnt_d = '0;
            st_cnt_d = '0;
        end else begin
            if (ld_acc && ld_cnt_q != '1) ld_cnt_d = ld_cnt_q + 32'd1;
            if (st_en && st_cnt_q != '1) st_cnt_d = st_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign ld_cnt = ld_cnt_q;
    assign st_cnt = st_cnt_q;
`endif

endmodule
